// File: rtl/insn_sequencer.sv
// insn_sequencer
//   Multi-cycle fetch/decode/execute controller for a small processor datapath.
//   Fetches a 32-bit instruction at pc over a req/ack insn-memory port, holds it in an
//   instruction register, drives register-bank / ALU / data-memory controls from its
//   fields, steps pc and counts retired instructions.
//
// Parameters
//   PC_W      width of pc and of the insn memory address
//   RESET_PC  pc value loaded on reset
//   CNT_W     width of the retired-instruction counter
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   start                    begin execution at pc (IDLE only)
//   imem_req/addr/ack/rdata  instruction fetch handshake
//   dmem_req/we/ack          data memory access handshake (we = store)
//   rf_src1/src2/dst         register bank addresses from the instruction register
//   alu_imm, alu_op          sign-extended immediate, 1 = add / 0 = subtract
//   wb_sel                   1 = ALU result, 0 = memory read data
//   rf_we                    one-cycle register write strobe in write-back
//   busy, halted             running / halt status
//   retired                  instructions completed through write-back
module insn_sequencer #(
  parameter int unsigned PC_W     = 5,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic [4:0]        rf_src1,
  output logic [4:0]        rf_src2,
  output logic [4:0]        rf_dst,
  output logic [31:0]       alu_imm,
  output logic              alu_op,
  output logic              wb_sel,
  output logic              rf_we,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned INSN_W = 32;
  localparam int unsigned FLD_W  = 5;
  localparam int unsigned USED_W = 25;

  // Decoded view of the used instruction bits [24:0]
  typedef struct packed {
    logic             halt;
    logic             r_src;
    logic             op;
    logic             r_w;
    logic             m_w;
    logic [FLD_W-1:0] imm;
    logic [FLD_W-1:0] dst;
    logic [FLD_W-1:0] src2;
    logic [FLD_W-1:0] src1;
  } insn_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  insn_t             ir_q, ir_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              imem_req_q, imem_req_d;
  logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic              rf_we_q, rf_we_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  // Bits [31:25] carry no meaning for this datapath
  logic unused_rsvd;
  assign unused_rsvd = ^imem_rdata[INSN_W-1:USED_W];

  // Next state, datapath registers and registered Moore outputs decoded from next state
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    retired_d   = retired_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = insn_t'(imem_rdata[USED_W-1:0]);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = ir_q.halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        // Loads with register write-back need memory data; stores always go to memory
        if (ir_q.m_w || (ir_q.r_w && !ir_q.r_src)) state_d = S_MEM;
        else                                        state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) state_d = S_WB;
      end
      S_WB: begin
        pc_d      = pc_q + PC_W'(1);
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    imem_req_d  = (state_d == S_FETCH);
    imem_addr_d = (state_d == S_FETCH) ? pc_d : PC_W'(0);
    dmem_req_d  = (state_d == S_MEM);
    dmem_we_d   = (state_d == S_MEM) && ir_d.m_w;
    rf_we_d     = (state_d == S_WB) && ir_d.r_w;
    busy_d      = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d    = (state_d == S_HALT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= PC_W'(RESET_PC);
      ir_q        <= insn_t'(0);
      retired_q   <= CNT_W'(0);
      imem_req_q  <= 1'b0;
      imem_addr_q <= PC_W'(0);
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      rf_we_q     <= rf_we_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign rf_we     = rf_we_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign retired   = retired_q;

  // Field outputs come straight from the instruction register
  assign rf_src1 = ir_q.src1;
  assign rf_src2 = ir_q.src2;
  assign rf_dst  = ir_q.dst;
  assign alu_imm = {{(INSN_W-FLD_W){ir_q.imm[FLD_W-1]}}, ir_q.imm};
  assign alu_op  = ir_q.op;
  assign wb_sel  = ir_q.r_src;

endmodule
